// File: rtl/kahan_start_multi.sv
// Kahan accumulation front end: masks and pairs NUM_ELEMS elements per beat and
// runs one zero-compensation kahan_step per pair, with plain/compensated mode.

module kahan_fp_add #(
  parameter int EW = 5,
  parameter int MW = 2
) (
  input  logic [EW+MW:0] a_i,
  input  logic [EW+MW:0] b_i,
  output logic [EW+MW:0] y_o
);
  localparam int BW = 1 + EW + MW;
  localparam int W  = MW + 4;  // hidden + mantissa + guard/round/sticky
  localparam logic [EW+1:0] E_ONE = {{(EW+1){1'b0}}, 1'b1};
  localparam logic [EW+1:0] E_MAX = {2'b00, {EW{1'b1}}};
  localparam logic [BW-1:0] QNAN  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic          a_nan, b_nan, a_inf, b_inf, swap, eff_sub, sticky, up;
  logic [BW-1:0] big, sml, res;
  logic [EW+1:0] be, se, diff, e;
  logic [W-1:0]  bsig, ssig, shifted, v;
  logic [W:0]    raw;
  logic [MW+1:0] sig;

  always_comb begin
    a_nan   = (&a_i[BW-2:MW]) & (|a_i[MW-1:0]);
    b_nan   = (&b_i[BW-2:MW]) & (|b_i[MW-1:0]);
    a_inf   = (&a_i[BW-2:MW]) & ~(|a_i[MW-1:0]);
    b_inf   = (&b_i[BW-2:MW]) & ~(|b_i[MW-1:0]);
    swap    = b_i[BW-2:0] > a_i[BW-2:0];
    big     = swap ? b_i : a_i;
    sml     = swap ? a_i : b_i;
    eff_sub = big[BW-1] ^ sml[BW-1];
    // subnormals share the minimum normal exponent with a clear hidden bit
    be      = (|big[BW-2:MW]) ? {2'b00, big[BW-2:MW]} : E_ONE;
    se      = (|sml[BW-2:MW]) ? {2'b00, sml[BW-2:MW]} : E_ONE;
    diff    = be - se;
    bsig    = {|big[BW-2:MW], big[MW-1:0], 3'b000};
    ssig    = {|sml[BW-2:MW], sml[MW-1:0], 3'b000};
    shifted = ssig >> diff;
    sticky  = |(ssig & ~({W{1'b1}} << diff));
    shifted[0] = shifted[0] | sticky;
    raw = eff_sub ? ({1'b0, bsig} - {1'b0, shifted}) : ({1'b0, bsig} + {1'b0, shifted});
    e = be;
    if (raw[W]) begin
      v = {raw[W:2], raw[1] | raw[0]};
      e = e + E_ONE;
    end else begin
      v = raw[W-1:0];
    end
    for (int i = 0; i < W; i++) begin
      if (!v[W-1] && e > E_ONE) begin
        v = v << 1;
        e = e - E_ONE;
      end
    end
    up  = v[2] & (v[3] | v[1] | v[0]);
    sig = {1'b0, v[W-1:3]} + {{(MW+1){1'b0}}, up};
    if (sig[MW+1]) begin
      sig = sig >> 1;
      e   = e + E_ONE;
    end
    if (e >= E_MAX) res = {big[BW-1], {EW{1'b1}}, {MW{1'b0}}};
    else            res = {big[BW-1], sig[MW] ? e[EW-1:0] : {EW{1'b0}}, sig[MW-1:0]};
    // exact cancellation gives +0 unless both operands were -0
    if (raw == '0) res = {big[BW-1] & ~eff_sub, {(BW-1){1'b0}}};
    if (a_nan | b_nan | (a_inf & b_inf & eff_sub)) res = QNAN;
    else if (a_inf)                               res = a_i;
    else if (b_inf)                               res = b_i;
    y_o = res;
  end
endmodule

module kahan_step #(
  parameter int EW = 5,
  parameter int MW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [EW+MW:0] elem_i,
  input  logic [EW+MW:0] sum_i,
  input  logic [EW+MW:0] c_i,
  output logic [EW+MW:0] sum_o,
  output logic [EW+MW:0] c_o
);
  localparam int BW = 1 + EW + MW;

  logic [BW-1:0] y, t, tmd, cn;
  logic [BW-1:0] t_q, t_d, s_q, s_d, y_q, y_d, sum_q, sum_d, c_q, c_d;

  kahan_fp_add #(.EW(EW), .MW(MW)) u_y (.a_i(elem_i), .b_i({~c_i[BW-1], c_i[BW-2:0]}), .y_o(y));
  kahan_fp_add #(.EW(EW), .MW(MW)) u_t (.a_i(sum_i),  .b_i(y), .y_o(t));
  kahan_fp_add #(.EW(EW), .MW(MW)) u_d (.a_i(t_q), .b_i({~s_q[BW-1], s_q[BW-2:0]}), .y_o(tmd));
  kahan_fp_add #(.EW(EW), .MW(MW)) u_c (.a_i(tmd), .b_i({~y_q[BW-1], y_q[BW-2:0]}), .y_o(cn));

  always_comb begin
    t_d   = t;
    s_d   = sum_i;
    y_d   = y;
    sum_d = t_q;
    c_d   = cn;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q   <= '0;
      s_q   <= '0;
      y_q   <= '0;
      sum_q <= '0;
      c_q   <= '0;
    end else begin
      t_q   <= t_d;
      s_q   <= s_d;
      y_q   <= y_d;
      sum_q <= sum_d;
      c_q   <= c_d;
    end
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;
endmodule

module kahan_start_multi #(
  parameter int EXP_WIDTH_I  = 5,
  parameter int MANT_WIDTH_I = 2,
  parameter int NUM_ELEMS    = 4,
  parameter int STEP_LAT     = 2
) (
  input  logic                                                        clk_i,
  input  logic                                                        rst_ni,
  input  logic                                                        valid_i,
  input  logic                                                        comp_en_i,
  input  logic [NUM_ELEMS-1:0]                                        mask_i,
  input  logic [NUM_ELEMS*(1+EXP_WIDTH_I+MANT_WIDTH_I)-1:0]           elems_i,
  output logic                                                        valid_o,
  output logic [((NUM_ELEMS+1)/2)*(1+EXP_WIDTH_I+MANT_WIDTH_I)-1:0]   sum_o,
  output logic [((NUM_ELEMS+1)/2)*(1+EXP_WIDTH_I+MANT_WIDTH_I)-1:0]   c_o,
  output logic [((NUM_ELEMS+1)/2)-1:0]                                special_o,
  output logic                                                        busy_o
);
  localparam int BW        = 1 + EXP_WIDTH_I + MANT_WIDTH_I;
  localparam int NUM_PAIRS = (NUM_ELEMS + 1) / 2;
  localparam int LAT       = STEP_LAT + 2;

  logic [NUM_ELEMS*BW-1:0]             elems_q, elems_d;
  logic [2*NUM_PAIRS*BW-1:0]           elems_pad;
  logic [STEP_LAT:0]                   vld_pipe_q, vld_pipe_d, cen_pipe_q, cen_pipe_d;
  logic [NUM_PAIRS-1:0][BW-1:0]        step_sum, step_c;
  logic [NUM_PAIRS-1:0][BW-1:0]        sum_q, sum_d, c_q, c_d;
  logic [NUM_PAIRS-1:0]                special_q, special_d;
  logic                                valid_q, valid_d;
  logic [LAT-1:0]                      inflight;

  always_comb begin
    for (int k = 0; k < NUM_ELEMS; k++)
      elems_d[k*BW +: BW] = mask_i[k] ? elems_i[k*BW +: BW] : '0;
    // stage 0 is the input register; stage STEP_LAT lines up with the step outputs
    vld_pipe_d = {vld_pipe_q[STEP_LAT-1:0], valid_i};
    cen_pipe_d = {cen_pipe_q[STEP_LAT-1:0], comp_en_i};
    // odd element counts leave the last pair's sum operand at +0
    elems_pad = '0;
    elems_pad[NUM_ELEMS*BW-1:0] = elems_q;
  end

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    kahan_step #(.EW(EXP_WIDTH_I), .MW(MANT_WIDTH_I)) u_step (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .elem_i (elems_pad[2*p*BW +: BW]),
      .sum_i  (elems_pad[(2*p+1)*BW +: BW]),
      .c_i    ({BW{1'b0}}),
      .sum_o  (step_sum[p]),
      .c_o    (step_c[p])
    );
  end

  always_comb begin
    valid_d = vld_pipe_q[STEP_LAT];
    sum_d   = step_sum;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      c_d[p]       = cen_pipe_q[STEP_LAT] ? step_c[p] : '0;
      special_d[p] = &step_sum[p][BW-2:MANT_WIDTH_I];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elems_q    <= '0;
      vld_pipe_q <= '0;
      cen_pipe_q <= '0;
      valid_q    <= 1'b0;
      sum_q      <= '0;
      c_q        <= '0;
      special_q  <= '0;
    end else begin
      elems_q    <= elems_d;
      vld_pipe_q <= vld_pipe_d;
      cen_pipe_q <= cen_pipe_d;
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      c_q        <= c_d;
      special_q  <= special_d;
    end
  end

  assign inflight  = {valid_q, vld_pipe_q};
  assign busy_o    = |inflight;
  assign valid_o   = valid_q;
  assign sum_o     = sum_q;
  assign c_o       = c_q;
  assign special_o = special_q;
endmodule

// File: tb/tb_kahan_start_multi.sv
// Directed bench for kahan_start_multi: 4-element and 3-element instances, E5M2.

module tb_kahan_start_multi;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v4, cen4, vo4, busy4;
  logic [3:0]  mask4;
  logic [31:0] el4;
  logic [15:0] sum4, c4;
  logic [1:0]  sp4;

  logic        v3, cen3, vo3, busy3;
  logic [2:0]  mask3;
  logic [23:0] el3;
  logic [15:0] sum3, c3;
  logic [1:0]  sp3;

  int checks = 0;
  int failures = 0;
  logic vin [0:11];

  kahan_start_multi u4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .comp_en_i(cen4), .mask_i(mask4),
    .elems_i(el4), .valid_o(vo4), .sum_o(sum4), .c_o(c4), .special_o(sp4), .busy_o(busy4));

  kahan_start_multi #(.NUM_ELEMS(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .comp_en_i(cen3), .mask_i(mask3),
    .elems_i(el3), .valid_o(vo3), .sum_o(sum3), .c_o(c3), .special_o(sp3), .busy_o(busy3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic run4(input string tag, input logic cen, input logic [3:0] m, input logic [31:0] e,
                      input logic [15:0] xs, input logic [15:0] xc, input logic [1:0] xsp);
    v4 = 1'b1; cen4 = cen; mask4 = m; el4 = e;
    tick();
    v4 = 1'b0;
    tick(); tick();
    chk({tag, ".early_valid"}, {31'd0, vo4}, 32'd0);
    tick();
    chk({tag, ".valid"},   {31'd0, vo4}, 32'd1);
    chk({tag, ".sum"},     {16'd0, sum4}, {16'd0, xs});
    chk({tag, ".c"},       {16'd0, c4},   {16'd0, xc});
    chk({tag, ".special"}, {30'd0, sp4},  {30'd0, xsp});
    chk({tag, ".busy"},    {31'd0, busy4}, 32'd1);
  endtask

  task automatic run3(input string tag, input logic [2:0] m, input logic [23:0] e,
                      input logic [15:0] xs, input logic [15:0] xc);
    v3 = 1'b1; cen3 = 1'b1; mask3 = m; el3 = e;
    tick();
    v3 = 1'b0;
    tick(); tick();
    chk({tag, ".early_valid"}, {31'd0, vo3}, 32'd0);
    tick();
    chk({tag, ".valid"},   {31'd0, vo3}, 32'd1);
    chk({tag, ".sum"},     {16'd0, sum3}, {16'd0, xs});
    chk({tag, ".c"},       {16'd0, c3},   {16'd0, xc});
    chk({tag, ".special"}, {30'd0, sp3},  32'd0);
  endtask

  initial begin
    logic xv, xb, cb;
    rst_n = 1'b0;
    v4 = 1'b1; cen4 = 1'b1; mask4 = 4'hF; el4 = 32'h7B7B7B7B;
    v3 = 1'b1; cen3 = 1'b1; mask3 = 3'h7; el3 = 24'h7B7B7B;
    #12;
    chk("rst.valid4", {31'd0, vo4}, 32'd0);
    chk("rst.sum4",   {16'd0, sum4}, 32'd0);
    chk("rst.c4",     {16'd0, c4}, 32'd0);
    chk("rst.sp4",    {30'd0, sp4}, 32'd0);
    chk("rst.busy4",  {31'd0, busy4}, 32'd0);
    chk("rst.valid3", {31'd0, vo3}, 32'd0);
    chk("rst.sum3",   {16'd0, sum3}, 32'd0);
    chk("rst.busy3",  {31'd0, busy3}, 32'd0);
    tick();
    v4 = 1'b0; v3 = 1'b0;
    rst_n = 1'b1;
    tick(); tick();

    // elems packed {e3,e2,e1,e0}; pair0 = e1+e0, pair1 = e3+e2
    run4("basic",    1'b1, 4'hF, 32'h403C3C3C, 16'h4240, 16'h0000, 2'b00);
    run4("comp",     1'b1, 4'hF, 32'h403C3C30, 16'h423C, 16'h00B0, 2'b00);
    run4("plain",    1'b0, 4'hF, 32'h403C3C30, 16'h423C, 16'h0000, 2'b00);
    run4("round_up", 1'b1, 4'hF, 32'h403C4334, 16'h4244, 16'h0034, 2'b00);
    run4("overflow", 1'b1, 4'hF, 32'h3C3C7B7B, 16'h407C, 16'h007C, 2'b01);
    run4("cancel_nan", 1'b1, 4'hF, 32'hFC7CBC3C, 16'h7E00, 16'h7E00, 2'b10);
    run4("all_masked", 1'b1, 4'h0, 32'h3C3C7B7B, 16'h0000, 16'h0000, 2'b00);
    run4("part_mask",  1'b1, 4'b0110, 32'h403C3C3C, 16'h3C3C, 16'h0000, 2'b00);
    run3("odd_mask", 3'b101, 24'h44403C, 16'h443C, 16'h0000);
    run3("odd_full", 3'b111, 24'h44403C, 16'h4442, 16'h0000);

    tick(); tick();
    for (int j = 0; j < 12; j++) vin[j] = (j != 8);
    // drive at step k is captured at the next edge and visible at step k+3
    for (int k = 0; k < 20; k++) begin
      v4 = (k < 12) ? vin[k] : 1'b0;
      cen4 = k[0];
      mask4 = 4'hF;
      el4 = 32'h403C3C30;
      tick();
      xv = (k >= 3 && k - 3 < 12) ? vin[k-3] : 1'b0;
      xb = 1'b0;
      for (int j = k - 3; j <= k; j++)
        if (j >= 0 && j < 12) xb = xb | vin[j];
      chk($sformatf("stream.valid[%0d]", k), {31'd0, vo4}, {31'd0, xv});
      chk($sformatf("stream.busy[%0d]", k),  {31'd0, busy4}, {31'd0, xb});
      if (xv) begin
        cb = ((k - 3) % 2) == 1;
        chk($sformatf("stream.sum[%0d]", k), {16'd0, sum4}, 32'h423C);
        chk($sformatf("stream.c[%0d]", k),   {16'd0, c4}, cb ? 32'h00B0 : 32'h0000);
      end
    end

    cen4 = 1'b1; mask4 = 4'hF; el4 = 32'h403C3C3C;
    for (int b = 0; b < 3; b++) begin
      v4 = 1'b1;
      tick();
    end
    v4 = 1'b0;
    tick(); tick();
    chk("midrst.pre_valid", {31'd0, vo4}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("midrst.valid", {31'd0, vo4}, 32'd0);
    chk("midrst.sum",   {16'd0, sum4}, 32'd0);
    chk("midrst.c",     {16'd0, c4}, 32'd0);
    chk("midrst.busy",  {31'd0, busy4}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("midrst.after_valid[%0d]", k), {31'd0, vo4}, 32'd0);
      chk($sformatf("midrst.after_busy[%0d]", k),  {31'd0, busy4}, 32'd0);
    end
    run4("recover", 1'b1, 4'hF, 32'h403C3C3C, 16'h4240, 16'h0000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/kahan_start_multi.md
# kahan_start_multi

Parametrised front end for the Kahan accumulation tree. It pairs up `NUM_ELEMS` floating-point elements per beat and runs one `kahan_step` per pair with zero incoming compensation. It emits `NUM_PAIRS` (sum, compensation) tuples plus a per-pair special-value flag. The block adds valid tracking, per-element masking, odd-count handling and a plain (uncompensated) mode, and feeds the downstream Kahan merge stages.

## Interface
- `EXP_WIDTH_I`, 5, exponent width of every element.
- `MANT_WIDTH_I`, 2, mantissa width of every element.
- `NUM_ELEMS`, 4, elements per beat, ≥2; odd values allowed.
- `STEP_LAT`, 2, pipeline depth of `kahan_step` in cycles; must match the instantiated step.
- Derived (localparam): `BIT_WIDTH_I` = 1+`EXP_WIDTH_I`+`MANT_WIDTH_I`; `NUM_PAIRS` = ceil(`NUM_ELEMS`/2); `LAT` = `STEP_LAT`+2.

Ports:
- `clk_i`, in, 1, clock.
- `rst_ni`, in, 1, reset; one clock, reset is asynchronous and active-low.
- `valid_i`, in, 1, beat qualifier; no backpressure, a beat is accepted every cycle it is high.
- `comp_en_i`, in, 1, 1 = compensated mode, 0 = plain mode; sampled with the beat.
- `mask_i`, in, `NUM_ELEMS`, 1 = element is valid, 0 = element is replaced by +0.
- `elems_i`, in, `NUM_ELEMS`*`BIT_WIDTH_I`, element k at bits [k*BW +: BW].
- `valid_o`, out, 1, output beat qualifier.
- `sum_o`, out, `NUM_PAIRS`*`BIT_WIDTH_I`, per-pair sum, pair p at [p*BW +: BW].
- `c_o`, out, `NUM_PAIRS`*`BIT_WIDTH_I`, per-pair compensation.
- `special_o`, out, `NUM_PAIRS`, 1 = `sum_o`[p] has an all-ones exponent (Inf or NaN).
- `busy_o`, out, 1, 1 while any accepted beat is still in flight (stages 0..`LAT`-1).

## Operation
- **Input stage.** Register `elems_i`, with element k forced to +0 (all zeros) when `mask_i`[k]=0. Also register `comp_en_i` and `valid_i`.
  - Data registers load every cycle regardless of `valid_i`.
  - `valid_o` is the only qualifier.
- **Pairing.** Pair p gets `elem_i` = element 2p and `sum_i` = element 2p+1, with `c_i` = +0.
  - When `NUM_ELEMS` is odd, the last pair's `sum_i` is +0.
- **Step.** Each `kahan_step` instance computes y = elem − c; t = sum + y; c_new = (t − sum) − y, returning (t, c_new). Rounding, Inf and NaN behaviour are exactly those of `kahan_step`.
- **Mode pipeline.** `comp_en` and valid travel in a `STEP_LAT`-deep shift register alongside the steps.
- **Output stage.** Register the results.
  - `c_o`[p] = step c when comp_en=1; +0 when comp_en=0.
  - `sum_o` is unaffected by mode.
  - `special_o`[p] = &exponent field of the step sum.
- `busy_o` = OR of all in-flight valid bits (input, shift register and output stage).

## Timing
- Latency is `LAT` cycles: a beat with `valid_i`=1 at edge n gives `valid_o`=1 with its results after edge n+`LAT`.
- Throughput is 1 beat/cycle. Back-to-back beats emerge back-to-back, and gaps are preserved.
- Reset: all data, mode and valid registers clear asynchronously. `valid_o`=0, `sum_o`=0, `c_o`=0, `special_o`=0, `busy_o`=0.
  - `kahan_step` internal state also resets.
- Reset asserted mid-flight drops every in-flight beat. No `valid_o` pulse follows release until new beats have travelled the full `LAT` cycles.
- `mask_i` and `comp_en_i` take effect per beat. Changing them between consecutive beats must not affect the neighbouring beat.
- Fully masked beat: all sums and compensations are +0, `special_o`=0, and `valid_o` still pulses.

## Test plan
- **Basic compensated add.** E5M2 defaults, `comp_en_i`=1, all masks 1, elems {0x3C,0x3C,0x3C,0x40} → after 4 cycles `valid_o`=1, sum={0x40,0x42}, c={0x00,0x00}, `special_o`=0.
- **Compensation capture.** elem0=0x30 (0.125), elem1=0x3C (1.0) → sum_o[0]=0x3C, c_o[0]=0xB0 (−0.125). Repeat with `comp_en_i`=0 → c_o[0]=0x00 and sum_o unchanged.
- **Masking and odd count.** `NUM_ELEMS`=3, elems {0x3C,0x40,0x44}, mask=3'b101 → sum_o[0]=0x3C, sum_o[1]=0x44, all c_o=0.
- **Overflow.** elems {0x7B,0x7B,...} → sum_o[0]=0x7C, special_o[0]=1; the other pairs (normal values) show special_o=0.
- **Streaming.** Send 8 back-to-back beats, one idle cycle, then 3 beats, with alternating `comp_en_i`. `valid_o` reproduces the same 8/gap/3 pattern delayed by exactly 4 cycles, each beat's c_o follows its own `comp_en_i`, and `busy_o` deasserts 4 cycles after the last beat.
- **Reset mid-flight.** Pulse `rst_ni` low 2 cycles after 3 beats are accepted → all outputs read 0 immediately, and no `valid_o` pulses for those beats after release.
